// File: rtl/instr_encoder.sv
// instr_encoder: accepts MIPS-style instruction field bundles, encodes them to 32-bit
// words and writes them sequentially to instruction memory. Optional macro: ENCODER_ILLEGAL_CHECK_EN.
`default_nettype none

module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [31:0]       enc_word;

    // Field forcing: shifts ignore rs, JR keeps only rs, other R-type zero shamt.
    always_comb begin
        enc_word = 32'h0000_0000;
        case (op_sel)
            5'd0:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
            5'd1:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h22};
            5'd2:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h24};
            5'd3:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h25};
            5'd4:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h26};
            5'd5:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h27};
            5'd6:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            5'd7:  enc_word = {6'h00, 5'd0, rt, rd, shamt, 6'h00};
            5'd8:  enc_word = {6'h00, 5'd0, rt, rd, shamt, 6'h02};
            5'd9:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h2B};
            5'd10: enc_word = {6'h00, rs, 5'd0, 5'd0, 5'd0, 6'h08};
            5'd11: enc_word = {6'h23, rs, rt, imm};
            5'd12: enc_word = {6'h2B, rs, rt, imm};
            5'd13: enc_word = {6'h08, rs, rt, imm};
            5'd14: enc_word = {6'h0D, rs, rt, imm};
            5'd15: enc_word = {6'h0E, rs, rt, imm};
            5'd16: enc_word = {6'h0C, rs, rt, imm};
            5'd17: enc_word = {6'h0A, rs, rt, imm};
            5'd18: enc_word = {6'h04, rs, rt, imm};
            5'd19: enc_word = {6'h05, rs, rt, imm};
            5'd20: enc_word = {6'h02, target};
            5'd21: enc_word = {6'h03, target};
            default: enc_word = 32'h0000_0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = count;
                    err_d   = 1'b0;
                    state_d = (count != '0) ? S_ACCEPT : S_DONE;
                end
            end
            S_ACCEPT: begin
                if (in_valid) begin
`ifdef ENCODER_ILLEGAL_CHECK_EN
                    if (op_sel >= 5'd22) begin
                        err_d = 1'b1;
                    end else begin
                        wdata_d = enc_word;
                        state_d = S_WRITE;
                    end
`else
                    wdata_d = enc_word;
                    state_d = S_WRITE;
`endif
                end
            end
            S_WRITE: begin
                if (mem_gnt) begin
                    addr_d  = addr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == {{(ADDR_W-1){1'b0}}, 1'b1}) ? S_DONE : S_ACCEPT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            wdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == S_ACCEPT);
    assign mem_req   = (state_q == S_WRITE);
    assign busy      = (state_q == S_ACCEPT) || (state_q == S_WRITE);
    assign done      = (state_q == S_DONE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;

endmodule

`default_nettype wire
